// File: rtl/toothless_pkg.sv
// Shared types for the toothless core front end: fetch FSM states, the NOP encoding
// and the payload carried from fetch to decode.
package toothless_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_DRAIN,
    FETCH_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO of fetched instructions with a synchronous clear used on flush.
// Depth need not be a power of two.
module fetch_fifo
  import toothless_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            push_i,
  input  fetch_entry_t    data_i,
  input  logic            pop_i,
  output fetch_entry_t    data_o,
  output logic            valid_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign valid_o = (count_q != '0);
  assign do_pop  = pop_i & valid_o;
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = ptr_inc(wptr_q);
      if (do_pop) rptr_d = ptr_inc(rptr_q);
      count_d = count_q + CntW'(push_i) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wptr_q] <= data_i;
  end

  // The fetch FSM only requests when space is guaranteed.
  assert property (@(posedge clk) disable iff (!rst_n) count_q <= CntW'(DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: OBI-style request/response to instruction memory, buffering of
// returned words with their PC, and flush handling for control transfers.
module instr_fetch
  import toothless_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  pc_i,
  output logic                   pc_advance_o,
  input  logic                   flush_i,
  output logic                   instr_req_o,
  output logic [ADDR_WIDTH-1:0]  instr_addr_o,
  input  logic                   instr_gnt_i,
  input  logic                   instr_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] instr_rdata_i,
  input  logic                   instr_err_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  output logic                   instr_fault_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, pc_aligned;
  logic                  stale_q, stale_d;

  fetch_entry_t    fifo_in, fifo_head;
  logic            fifo_valid, fifo_push, fifo_pop;
  logic [CntW-1:0] fifo_count;
  logic            space_after_push;

  assign pc_aligned = pc_i & ~ADDR_WIDTH'(3);
  assign fifo_push  = (state_q == FETCH_WAIT) & instr_rvalid_i & ~flush_i;
  assign fifo_pop   = fifo_valid & instr_ready_i & ~flush_i;

  // Occupancy after this cycle's push, accounting for a same-cycle pop.
  assign space_after_push = fifo_pop ? (fifo_count < DepthC)
                                     : (fifo_count < DepthC - CntW'(1));

  always_comb begin
    fifo_in       = '0;
    fifo_in.instr = XLEN'(instr_rdata_i);
    fifo_in.pc    = XLEN'(addr_q);
    fifo_in.fault = instr_err_i;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CntW  (CntW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush_i),
    .push_i  (fifo_push),
    .data_i  (fifo_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_IDLE;
      addr_q  <= '0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      stale_q <= stale_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    stale_d = stale_q;
    case (state_q)
      FETCH_IDLE: begin
        if (!flush_i && (fifo_count < DepthC)) begin
          state_d = FETCH_REQ;
          addr_d  = pc_aligned;
        end
      end
      FETCH_REQ: begin
        // A flushed request must still complete its handshake; its response is drained.
        if (instr_gnt_i) begin
          state_d = (stale_q || flush_i) ? FETCH_DRAIN : FETCH_WAIT;
          stale_d = 1'b0;
        end else if (flush_i) begin
          stale_d = 1'b1;
        end
      end
      FETCH_WAIT: begin
        if (flush_i) begin
          state_d = instr_rvalid_i ? FETCH_IDLE : FETCH_DRAIN;
        end else if (instr_rvalid_i) begin
          if (instr_err_i) begin
            state_d = FETCH_HALT;
          end else if (space_after_push) begin
            state_d = FETCH_REQ;
            addr_d  = pc_aligned;
          end else begin
            state_d = FETCH_IDLE;
          end
        end
      end
      FETCH_DRAIN: begin
        if (instr_rvalid_i) state_d = FETCH_IDLE;
      end
      FETCH_HALT: begin
        if (flush_i) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_comb begin
    instr_req_o   = (state_q == FETCH_REQ);
    instr_addr_o  = addr_q;
    pc_advance_o  = instr_req_o & instr_gnt_i & ~flush_i & ~stale_q;
    instr_valid_o = fifo_valid;
    instr_o       = fifo_valid ? INSTR_WIDTH'(fifo_head.instr) : INSTR_WIDTH'(INSTR_NOP);
    instr_pc_o    = fifo_valid ? ADDR_WIDTH'(fifo_head.pc) : '0;
    instr_fault_o = fifo_valid & fifo_head.fault;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory/PC model drives the DUT, tests queue the
// expected instruction stream, and a monitor checks every decoder handshake in order.
module tb_instr_fetch;
  import toothless_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_advance_o;
  logic        flush_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_fault_o;

  logic        gnt_en;
  int          rv_lat;
  logic [31:0] err_addr;
  logic        pend;
  logic [31:0] paddr;
  int          wcnt;

  int n_cmp   = 0;
  int n_err   = 0;
  int n_deliv = 0;
  int adv_cnt = 0;

  fetch_entry_t exp_q[$];

  always #5 clk = ~clk;
  assign instr_gnt_i = gnt_en;

  instr_fetch #(
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_i           (pc),
    .pc_advance_o   (pc_advance_o),
    .flush_i        (flush_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o),
    .instr_fault_o  (instr_fault_o)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, 16'h0013};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    fetch_entry_t e;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      e.pc    = start + 32'(4 * i);
      e.instr = data_of(e.pc);
      e.fault = (e.pc == err_addr);
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_deliv(input string name, input int n, input int budget);
    int target = n_deliv + n;
    int t = 0;
    while (n_deliv < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(name, 32'(n_deliv >= target), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(instr_req_o), 32'd0);
    chk({tag, "_addr"}, instr_addr_o, 32'd0);
    chk({tag, "_adv"}, 32'(pc_advance_o), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
    chk({tag, "_instr_nop"}, instr_o, 32'h0000_0013);
    chk({tag, "_pc"}, instr_pc_o, 32'd0);
    chk({tag, "_fault"}, 32'(instr_fault_o), 32'd0);
  endtask

  // Instruction memory and program_counter model.
  initial begin
    logic        hs, adv;
    logic [31:0] a_s;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    instr_err_i    = 1'b0;
    pend           = 1'b0;
    paddr          = '0;
    wcnt           = 0;
    forever begin
      @(negedge clk);
      hs  = instr_req_o & instr_gnt_i;
      adv = pc_advance_o;
      a_s = instr_addr_o;
      @(posedge clk);
      #1;
      if (adv) begin
        pc = pc + 32'd4;
        adv_cnt++;
      end
      if (hs && rst_n) begin
        pend  = 1'b1;
        paddr = a_s;
        wcnt  = rv_lat;
      end
      instr_rvalid_i = 1'b0;
      instr_err_i    = 1'b0;
      if (pend && rst_n) begin
        if (wcnt <= 1) begin
          instr_rvalid_i = 1'b1;
          instr_rdata_i  = data_of(paddr);
          instr_err_i    = (paddr == err_addr);
          pend           = 1'b0;
        end else begin
          wcnt--;
        end
      end
    end
  end

  // Monitor: every accepted decoder handshake is checked against the scoreboard.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid_o && instr_ready_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_instr: got pc %08h, expected no delivery", instr_pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc_o, e.pc);
          chk("instr", instr_o, e.instr);
          chk("instr_fault", 32'(instr_fault_o), 32'(e.fault));
        end
        n_deliv++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base, rq, t;
    logic [31:0] a0;
    pc            = 32'h0001_0074;
    flush_i       = 1'b0;
    instr_ready_i = 1'b1;
    gnt_en        = 1'b1;
    rv_lat        = 1;
    err_addr      = 32'hFFFF_FFFC;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");

    // 1. zero-wait streaming
    push_stream(32'h0001_0074, 64);
    cyc();
    rst_n = 1'b1;
    wait_deliv("t1_stream", 6, 60);

    // 2. decoder stalled: FIFO fills to DEPTH and requests stop
    cyc();
    flush_i       = 1'b1;
    instr_ready_i = 1'b0;
    pc            = 32'h0001_0300;
    push_stream(32'h0001_0300, 64);
    base = adv_cnt;
    cyc();
    flush_i = 1'b0;
    repeat (12) @(negedge clk);
    chk("t2_adv_pulses", 32'(adv_cnt - base), 32'(DEPTH));
    chk("t2_req_low", 32'(instr_req_o), 32'd0);
    chk("t2_valid_held", 32'(instr_valid_o), 32'd1);
    cyc();
    instr_ready_i = 1'b1;
    wait_deliv("t2_release", 4, 60);

    // 3. grant withheld: request held stable, one advance on grant
    cyc();
    gnt_en = 1'b0;
    t = 0;
    @(negedge clk);
    while (!instr_req_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("t3_req_seen", 32'(instr_req_o), 32'd1);
    a0   = instr_addr_o;
    base = adv_cnt;
    repeat (3) begin
      @(negedge clk);
      chk("t3_addr_stable", instr_addr_o, a0);
      chk("t3_no_adv", 32'(pc_advance_o), 32'd0);
    end
    cyc();
    gnt_en = 1'b1;
    @(negedge clk);
    chk("t3_adv_on_gnt", 32'(pc_advance_o), 32'd1);
    @(negedge clk);
    chk("t3_single_adv", 32'(adv_cnt - base), 32'd1);
    wait_deliv("t3_resume", 3, 60);

    // 4. flush while a response is outstanding
    cyc();
    rv_lat = 4;
    t = 0;
    while (!pend && t < 40) begin
      cyc();
      t++;
    end
    chk("t4_in_wait", 32'(pend), 32'd1);
    flush_i = 1'b1;
    pc      = 32'h0001_0200;
    push_stream(32'h0001_0200, 64);
    cyc();
    flush_i = 1'b0;
    rv_lat  = 1;
    wait_deliv("t4_after_flush", 3, 80);

    // 5. bus error: faulting entry delivered, then no further requests
    cyc();
    flush_i  = 1'b1;
    err_addr = 32'h0001_0080;
    pc       = 32'h0001_0078;
    push_stream(32'h0001_0078, 3);
    cyc();
    flush_i = 1'b0;
    wait_deliv("t5_deliver", 3, 60);
    base = adv_cnt;
    rq   = 0;
    repeat (10) begin
      @(negedge clk);
      if (instr_req_o) rq++;
    end
    chk("t5_no_req_halted", 32'(rq), 32'd0);
    chk("t5_no_adv_halted", 32'(adv_cnt - base), 32'd0);

    // 6. reset mid-WAIT with one buffered entry
    cyc();
    flush_i       = 1'b1;
    err_addr      = 32'hFFFF_FFFC;
    instr_ready_i = 1'b0;
    rv_lat        = 4;
    pc            = 32'h0001_0500;
    push_stream(32'h0001_0500, 64);
    cyc();
    flush_i = 1'b0;
    t = 0;
    while (!(instr_valid_o && pend) && t < 40) begin
      cyc();
      t++;
    end
    chk("t6_setup", 32'(instr_valid_o && pend), 32'd1);
    rst_n          = 1'b0;
    pend           = 1'b0;
    instr_rvalid_i = 1'b0;
    exp_q.delete();
    pc = 32'h0001_0402;
    #1;
    chk_reset_outputs("t6_reset");
    instr_ready_i = 1'b1;
    rv_lat        = 1;
    push_stream(32'h0001_0400, 64);
    repeat (2) @(posedge clk);
    cyc();
    rst_n = 1'b1;
    wait_deliv("t6_after_reset", 4, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
